i2c_master_wr: RTL and testbench
================================

Name: i2c_master_wr

Overview:
- Single-byte I2C write master: START, 7-bit address with W bit, ACK check, one data byte, ACK check, STOP.
- Sits directly downstream of the team's clock-divider stage.
- Advances one quarter-bit phase per divider `tick` (single-cycle clock enable), so SCL/SDA are generated entirely in the `clk` domain. There is no derived-clock logic.
- Drives open-drain-style line enables toward the pad layer.

Parameters:
- STRETCH_EN, 1, when 1 a low `scl_in` during a released-SCL phase holds the phase counter (clock stretching).
- CHK_ACK, 1, when 1 a NACK aborts to STOP and sets `ack_err`; when 0 ACK bits are ignored.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tick  input  1  one-cycle phase enable from the clock divider
- start  input  1  request a transaction; sampled only in IDLE
- addr  input  7  slave address, latched on accept
- data  input  8  write byte, latched on accept
- scl_in  input  1  sampled SCL line (for stretching)
- sda_in  input  1  sampled SDA line (for ACK)
- scl_o  output  1  1 = release SCL, 0 = pull low
- sda_o  output  1  1 = release SDA, 0 = pull low
- busy  output  1  high from accept until STOP completes
- done  output  1  one-cycle pulse when the transaction ends
- ack_err  output  1  NACK seen in the last transaction; cleared on next accept

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: state=IDLE, phase=0, `scl_o`=1, `sda_o`=1, `busy`=0, `done`=0, `ack_err`=0.
- Reset mid-transaction: the lines are released on the next `clk` edge and no STOP is generated.
- States: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP.
- Phase counter p: 2 bits (0..3). It changes only on `tick`.
- Accept: in IDLE with `start`=1 (`tick` not required):
  - latch `shreg` = {addr, 1'b0}, latch data, clear `ack_err`, set `busy`=1, go to START p0.
  - `start` while `busy` is ignored.
- START: p0 scl=1 sda=1; p1 scl=1 sda=0; p2 scl=1 sda=0; p3 scl=0 sda=0; then ADDR bit 7.
- Bit phases (ADDR, DATA):
  - p0 scl=0, sda=current MSB of the shift register; p1 scl=0; p2 scl=1; p3 scl=1.
  - The tick leaving p3 shifts left; after 8 bits, move to ACK.
  - Bits are MSB first. The ADDR byte is addr[6:0] followed by 0.
- ACK1/ACK2:
  - Same phases with sda=1 (released).
  - `sda_in` is sampled on the tick leaving p2.
  - If the sample is 1 and CHK_ACK=1: set `ack_err`=1; after p3 go to STOP.
  - Otherwise ACK1 goes to DATA and ACK2 goes to STOP.
- STOP: p0 scl=0 sda=0; p1 scl=1 sda=0; p2 scl=1 sda=1; p3 scl=1 sda=1.
  - The tick leaving p3 goes to IDLE, `busy`=0, `done`=1 for exactly one `clk`.
- Stretching (STRETCH_EN=1): in bit/ACK p2, a tick with `scl_in`=0 is ignored (phase held) until a tick sees `scl_in`=1.
- Nominal duration: 80 ticks (START 4 + 9×4 + 9×4 + STOP 4). A NACK at ACK1 gives 44 ticks.
- `tick` asserted every cycle is legal (minimum period).
- Outputs are registered and change only on the `clk` edge where `tick` is consumed.

Decomposition:
- Package `i2c_pkg`:
  - state enum `i2c_st_t`
  - phase width constant `I2C_PH_W`=2
  - `I2C_ADDR_W`=7
  - `I2C_BYTE_W`=8
  - `I2C_WR_BIT`=1'b0
- No sub-module. The shift register, bit counter (0..7) and phase counter are inline.
- The upstream divider supplies `tick`.

Test Plan:
- `tick` every 4 clk, addr=7'h50, data=8'hA5, `sda_in` pulled low at both ACKs:
  - SDA bit sequence 1010_0000 then 1010_0101
  - `done` pulse after 80 ticks, `ack_err`=0
  - START (SDA falls with SCL high) and STOP (SDA rises with SCL high) observed.
- Same as above but `sda_in`=1 at ACK1:
  - `ack_err`=1, no data bits driven, STOP follows, `done` after 44 ticks.
- CHK_ACK=0 with `sda_in`=1 always:
  - full 80-tick transaction, `ack_err`=0.
- `scl_in` held low 10 ticks during ADDR bit 3 p2 (STRETCH_EN=1):
  - phase frozen, total 90 ticks, data bits unchanged.
- `start` pulsed again at tick 20 of a transaction:
  - ignored, latched addr/data unchanged, single `done`.
- `reset` asserted during DATA bit 4:
  - next clk `scl_o`=`sda_o`=1, `busy`=0, no `done`.
  - A new `start` then completes normally.

Source files
------------

// File: rtl/i2c_master_wr_pkg.sv
// i2c_pkg: shared types and constants for the single-byte I2C write master.
//   i2c_st_t   - transaction state
//   I2C_*      - phase/address/byte widths and the R/W bit value for a write
//   scl_level / sda_level - line level for a given state and quarter-bit phase
package i2c_pkg;

    localparam int   I2C_PH_W   = 2;
    localparam int   I2C_ADDR_W = 7;
    localparam int   I2C_BYTE_W = 8;
    localparam logic I2C_WR_BIT = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK1,
        ST_DATA,
        ST_ACK2,
        ST_STOP
    } i2c_st_t;

    // SCL level (1 = released) for a state/phase pair.
    function automatic logic scl_level(input i2c_st_t st, input logic [I2C_PH_W-1:0] ph);
        logic r;
        r = 1'b1;
        case (st)
            ST_START:                          r = (ph != 2'd3);
            ST_ADDR, ST_DATA, ST_ACK1, ST_ACK2: r = ph[1];
            ST_STOP:                           r = (ph != 2'd0);
            default:                           r = 1'b1;
        endcase
        return r;
    endfunction

    // SDA level (1 = released); msb is the bit currently being shifted out.
    function automatic logic sda_level(input i2c_st_t st, input logic [I2C_PH_W-1:0] ph,
                                       input logic msb);
        logic r;
        r = 1'b1;
        case (st)
            ST_START:         r = (ph == 2'd0);
            ST_ADDR, ST_DATA: r = msb;
            ST_STOP:          r = ph[1];
            default:          r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_master_wr.sv
// i2c_master_wr: single-byte I2C write master (START, addr+W, ACK, data, ACK, STOP).
// Advances one quarter-bit phase per `tick`; everything lives in the clk domain.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   tick              - one-cycle phase enable from the clock divider
//   start, addr, data - transaction request (sampled in IDLE) and its payload
//   scl_in, sda_in    - sampled bus lines (clock stretching, ACK)
//   scl_o, sda_o      - open-drain enables, 1 = release
//   busy, done        - transaction in progress / one-cycle completion pulse
//   ack_err           - NACK seen during the last transaction
module i2c_master_wr
    import i2c_pkg::*;
#(
    parameter bit STRETCH_EN = 1'b1,
    parameter bit CHK_ACK    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic [I2C_ADDR_W-1:0] addr,
    input  logic [I2C_BYTE_W-1:0] data,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  scl_o,
    output logic                  sda_o,
    output logic                  busy,
    output logic                  done,
    output logic                  ack_err
);

    localparam int BIT_W = $clog2(I2C_BYTE_W);

    i2c_st_t               state, nxt_state;
    logic [I2C_PH_W-1:0]   phase, nxt_phase;
    logic [BIT_W-1:0]      bit_cnt, nxt_bit_cnt;
    logic [I2C_BYTE_W-1:0] shreg, nxt_shreg;
    logic [I2C_BYTE_W-1:0] data_q, nxt_data_q;
    logic                  nxt_busy, nxt_done, nxt_ack_err;
    logic                  in_bit, stretch;

    assign in_bit  = (state == ST_ADDR) || (state == ST_DATA) ||
                     (state == ST_ACK1) || (state == ST_ACK2);
    // A slave holding SCL low while we have released it freezes the phase.
    assign stretch = STRETCH_EN && in_bit && (phase == 2'd2) && !scl_in;

    always_comb begin
        nxt_state   = state;
        nxt_phase   = phase;
        nxt_bit_cnt = bit_cnt;
        nxt_shreg   = shreg;
        nxt_data_q  = data_q;
        nxt_busy    = busy;
        nxt_done    = 1'b0;
        nxt_ack_err = ack_err;
        if (state == ST_IDLE) begin
            if (start) begin
                nxt_state   = ST_START;
                nxt_phase   = '0;
                nxt_bit_cnt = '0;
                nxt_shreg   = {addr, I2C_WR_BIT};
                nxt_data_q  = data;
                nxt_busy    = 1'b1;
                nxt_ack_err = 1'b0;
            end
        end else if (tick && !stretch) begin
            nxt_phase = phase + 1'b1;
            case (state)
                ST_START: if (phase == 2'd3) nxt_state = ST_ADDR;
                ST_ADDR, ST_DATA: begin
                    if (phase == 2'd3) begin
                        nxt_shreg   = {shreg[I2C_BYTE_W-2:0], 1'b0};
                        nxt_bit_cnt = bit_cnt + 1'b1;   // wraps to 0 after the last bit
                        if (bit_cnt == BIT_W'(I2C_BYTE_W - 1))
                            nxt_state = (state == ST_ADDR) ? ST_ACK1 : ST_ACK2;
                    end
                end
                ST_ACK1, ST_ACK2: begin
                    if (phase == 2'd2 && sda_in && CHK_ACK) nxt_ack_err = 1'b1;
                    if (phase == 2'd3) begin
                        // ack_err was cleared on accept, so here it means a NACK this transaction
                        if (ack_err || state == ST_ACK2) begin
                            nxt_state = ST_STOP;
                        end else begin
                            nxt_state = ST_DATA;
                            nxt_shreg = data_q;
                        end
                    end
                end
                ST_STOP: begin
                    if (phase == 2'd3) begin
                        nxt_state = ST_IDLE;
                        nxt_busy  = 1'b0;
                        nxt_done  = 1'b1;
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase
        end
    end

    // Line outputs are registered from the next state so they move on the same
    // edge that consumes the tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= '0;
            scl_o   <= 1'b1;
            sda_o   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state   <= nxt_state;
            phase   <= nxt_phase;
            bit_cnt <= nxt_bit_cnt;
            shreg   <= nxt_shreg;
            data_q  <= nxt_data_q;
            scl_o   <= scl_level(nxt_state, nxt_phase);
            sda_o   <= sda_level(nxt_state, nxt_phase, nxt_shreg[I2C_BYTE_W-1]);
            busy    <= nxt_busy;
            done    <= nxt_done;
            ack_err <= nxt_ack_err;
        end
    end

endmodule

// File: tb/tb_i2c_master_wr.sv
// tb_i2c_master_wr: directed bench for i2c_master_wr. A bus monitor records SCL-rising
// SDA bits, START/STOP conditions and consumed ticks; expected transactions are queued
// when started and compared when `done` fires.
module tb_i2c_master_wr;

    logic       clk = 1'b0;
    logic       reset, tick = 1'b0, start, sda_in, scl_hold;
    logic [6:0] addr;
    logic [7:0] data;
    logic       scl_o, sda_o, busy, done, ack_err;
    logic       nc_scl_o, nc_sda_o, nc_busy, nc_done, nc_ack_err;
    logic       scl_in, nc_scl_in;

    // Wired-AND SCL: the bench can stretch by holding the line low.
    assign scl_in    = scl_o & ~scl_hold;
    assign nc_scl_in = nc_scl_o & ~scl_hold;

    i2c_master_wr #(.STRETCH_EN(1'b1), .CHK_ACK(1'b1)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .addr(addr), .data(data),
        .scl_in(scl_in), .sda_in(sda_in), .scl_o(scl_o), .sda_o(sda_o),
        .busy(busy), .done(done), .ack_err(ack_err));

    i2c_master_wr #(.STRETCH_EN(1'b1), .CHK_ACK(1'b0)) dut_nc (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .addr(addr), .data(data),
        .scl_in(nc_scl_in), .sda_in(sda_in), .scl_o(nc_scl_o), .sda_o(nc_sda_o),
        .busy(nc_busy), .done(nc_done), .ack_err(nc_ack_err));

    initial forever #5 clk = ~clk;

    // tick: one cycle in four, changing just after the rising edge
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (div == 3);
            div  = (div + 1) % 4;
        end
    end

    // ---------------- bus monitor ----------------
    int          nticks = 0, nbits = 0, nstart = 0, nstop = 0, ndone = 0;
    logic [31:0] bits = '0;
    logic        pscl = 1'b1, psda = 1'b1, pbusy = 1'b0;
    int          nc_ticks = 0;
    logic        nc_pbusy = 1'b0;

    always @(negedge clk) begin
        pscl  <= scl_o;
        psda  <= sda_o;
        pbusy <= busy;
        if (done) ndone <= ndone + 1;
        if (busy && !pbusy) begin
            nticks <= (tick) ? 1 : 0;
            nbits  <= 0;
            bits   <= '0;
            nstart <= 0;
            nstop  <= 0;
        end else begin
            if (tick && busy) nticks <= nticks + 1;
            if (!pscl && scl_o) begin
                bits  <= {bits[30:0], sda_o};
                nbits <= nbits + 1;
            end
            if (pscl && scl_o && psda && !sda_o) nstart <= nstart + 1;
            if (pscl && scl_o && !psda && sda_o) nstop  <= nstop + 1;
        end
    end

    always @(negedge clk) begin
        nc_pbusy <= nc_busy;
        if (nc_busy && !nc_pbusy) nc_ticks <= (tick) ? 1 : 0;
        else if (tick && nc_busy) nc_ticks <= nc_ticks + 1;
    end

    // ---------------- scoreboard / checking ----------------
    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          ticks;
        logic        ack_err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_full(input logic [6:0] a, input logic [7:0] d, input int t);
        exp_t e;
        e.bits    = {13'd0, a, 1'b0, 1'b1, d, 1'b1, 1'b0};   // addr+W, ACK, data, ACK, STOP rise
        e.nbits   = 19;
        e.ticks   = t;
        e.ack_err = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_nack(input logic [6:0] a);
        exp_t e;
        e.bits    = {22'd0, a, 1'b0, 1'b1, 1'b0};              // addr+W, NACK, STOP rise
        e.nbits   = 10;
        e.ticks   = 44;
        e.ack_err = 1'b1;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ticks(input string tag, input int n);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (nticks >= n) ok = 1'b1;
        end
        chk({tag, ".reach"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_check(input string tag);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        #1;
        chk({tag, ".done"}, 32'(seen), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".ticks"},   32'(nticks), 32'(e.ticks));
            chk({tag, ".bits"},    bits,        e.bits);
            chk({tag, ".nbits"},   32'(nbits),  32'(e.nbits));
            chk({tag, ".ack_err"}, 32'(ack_err), 32'(e.ack_err));
            chk({tag, ".start"},   32'(nstart), 32'd1);
            chk({tag, ".stop"},    32'(nstop),  32'd1);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000 && (busy || nc_busy); k++) @(negedge clk);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        bit seen;
        int d0;
        reset = 1'b1; start = 1'b0; addr = '0; data = '0; sda_in = 1'b0; scl_hold = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.scl",     32'(scl_o),    32'd1);
        chk("rst.sda",     32'(sda_o),    32'd1);
        chk("rst.busy",    32'(busy),     32'd0);
        chk("rst.done",    32'(done),     32'd0);
        chk("rst.ack_err", 32'(ack_err),  32'd0);
        chk("rst.nc_sda",  32'(nc_sda_o), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // nominal write, slave ACKs both bytes
        sda_in = 1'b0;
        push_full(7'h50, 8'hA5, 80);
        do_start(7'h50, 8'hA5);
        chk("t1.busy", 32'(busy), 32'd1);
        wait_check("t1");
        wait_idle();

        // NACK at address: main aborts after 44 ticks; CHK_ACK=0 instance runs to 80
        sda_in = 1'b1;
        push_nack(7'h50);
        do_start(7'h50, 8'hA5);
        wait_check("t2");
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (nc_done) seen = 1'b1;
        end
        #1;
        chk("t3.nc_done",    32'(seen),       32'd1);
        chk("t3.nc_ticks",   32'(nc_ticks),   32'd80);
        chk("t3.nc_ack_err", 32'(nc_ack_err), 32'd0);
        wait_idle();

        // clock stretch: hold SCL low through ten ticks of the fourth address bit's p2
        sda_in = 1'b0;
        push_full(7'h50, 8'hA5, 90);
        do_start(7'h50, 8'hA5);
        wait_ticks("t4.hold", 18);
        scl_hold = 1'b1;
        wait_ticks("t4.mid", 24);
        chk("t4.frozen_bits", 32'(nbits), 32'd4);
        chk("t4.frozen_scl",  32'(scl_o), 32'd1);
        wait_ticks("t4.rel", 29);
        scl_hold = 1'b0;
        wait_check("t4");
        wait_idle();

        // second start mid-transaction is ignored, payload stays latched
        push_full(7'h2B, 8'h3C, 80);
        do_start(7'h2B, 8'h3C);
        wait_ticks("t5.mid", 20);
        do_start(7'h11, 8'hFF);
        wait_check("t5");
        d0 = ndone;
        repeat (400) @(negedge clk);
        chk("t5.single_done", 32'(ndone), 32'(d0));
        chk("t5.idle",        32'(busy),  32'd0);

        // reset during DATA bit 4 (a 0 bit of A5): lines released, no done
        do_start(7'h50, 8'hA5);
        wait_ticks("t6.mid", 58);
        chk("t6.sda_low", 32'(sda_o), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6.scl",  32'(scl_o), 32'd1);
        chk("t6.sda",  32'(sda_o), 32'd1);
        chk("t6.busy", 32'(busy),  32'd0);
        chk("t6.done", 32'(done),  32'd0);
        reset = 1'b0;
        d0 = ndone;
        repeat (400) @(negedge clk);
        chk("t6.no_done", 32'(ndone), 32'(d0));

        // fresh transaction after reset
        push_full(7'h3A, 8'h5C, 80);
        do_start(7'h3A, 8'h5C);
        wait_check("t7");
        chk("t7.sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
